// File: rtl/led_fader_if.sv
// LED fader pin bundle: pattern request in, dimmed pin drive and PWM
// period marker out.
interface led_fader_if #(
    parameter int N_LEDS = 4
);
    logic [N_LEDS-1:0] led_in;
    logic [N_LEDS-1:0] led_out;
    logic              pwm_wrap;

    modport master (
        output led_in,
        input  led_out,
        input  pwm_wrap
    );

    modport slave (
        input  led_in,
        output led_out,
        output pwm_wrap
    );
endinterface

// File: rtl/led_fader.sv
// PWM LED fader: asserted channels snap to full brightness, released
// channels decay linearly to off, giving a comet trail behind the pattern.
module led_fader #(
    parameter int N_LEDS     = 4,
    parameter int PWM_BITS   = 8,
    parameter int DECAY_DIV  = 16,
    parameter int DECAY_STEP = 8
) (
    input logic       clk,
    input logic       rst,
    led_fader_if.slave bus
);

    localparam logic [PWM_BITS-1:0] MAX  = '1;
    localparam logic [PWM_BITS:0]   STEP = (PWM_BITS+1)'(DECAY_STEP);

    logic [PWM_BITS-1:0]  pwm_cnt;
    logic [DECAY_DIV-1:0] decay_cnt;
    logic                 period_end;
    logic                 tick;

    logic [PWM_BITS-1:0] bright     [N_LEDS];
    logic [PWM_BITS-1:0] bright_nxt [N_LEDS];
    logic [PWM_BITS-1:0] duty       [N_LEDS];
    logic [PWM_BITS:0]   diff       [N_LEDS];

    logic [N_LEDS-1:0] led_q;
    logic [N_LEDS-1:0] led_nxt;
    logic              wrap_q;

    assign period_end   = (pwm_cnt == MAX);
    assign tick         = &decay_cnt;
    assign bus.led_out  = led_q;
    assign bus.pwm_wrap = wrap_q;

    // Decay is computed one bit wider so an underflow shows up as the
    // top bit and clamps to zero instead of wrapping to a bright value.
    always_comb begin
        led_nxt = '0;
        for (int i = 0; i < N_LEDS; i++) begin
            diff[i]       = {1'b0, bright[i]} - STEP;
            bright_nxt[i] = bright[i];
            if (bus.led_in[i]) begin
                bright_nxt[i] = MAX;
            end else if (tick) begin
                bright_nxt[i] = diff[i][PWM_BITS] ? '0
                                                  : diff[i][PWM_BITS-1:0];
            end
            led_nxt[i] = (duty[i] == MAX) || (pwm_cnt < duty[i]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pwm_cnt   <= '0;
            decay_cnt <= '0;
            led_q     <= '0;
            wrap_q    <= 1'b0;
        end else begin
            pwm_cnt   <= pwm_cnt + 1'b1;
            decay_cnt <= decay_cnt + 1'b1;
            led_q     <= led_nxt;
            wrap_q    <= period_end;
        end
    end

    // Duty is a shadow of brightness latched only at the period boundary,
    // so the pin waveform never changes shape mid-period.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_LEDS; i++) begin
                bright[i] <= '0;
                duty[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < N_LEDS; i++) begin
                bright[i] <= bright_nxt[i];
                if (period_end) begin
                    duty[i] <= bright[i];
                end
            end
        end
    end

endmodule

// File: tb/tb_led_fader.sv
// Directed bench for led_fader with a fast decay prescaler
// (PWM_BITS=8, DECAY_DIV=4, DECAY_STEP=8).
module tb_led_fader;

    logic clk = 1'b0;
    logic rst = 1'b1;

    led_fader_if #(.N_LEDS(4)) bus ();

    led_fader #(
        .N_LEDS    (4),
        .PWM_BITS  (8),
        .DECAY_DIV (4),
        .DECAY_STEP(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [3:0] pat;
        logic [3:0] exp_out;
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)",
                     name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        bus.led_in = '0;
        rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #2;
        chk("rst_led_out", 32'(bus.led_out), 0);
        chk("rst_pwm_wrap", 32'(bus.pwm_wrap), 0);
        rst = 1'b0;
    endtask

    // Pulse one channel on edge 255, then watch the full period, the
    // 127-duty period and the decay to zero.
    task automatic run_pulse(input int ch);
        logic [3:0] onehot;
        int         hi;
        int         m;
        logic [3:0] exp_out;
        onehot = 4'b0001 << ch;
        hi = 0;
        do_reset();
        for (int e = 1; e <= 1100; e++) begin
            bus.led_in = (e == 255) ? onehot : 4'b0000;
            step();
            exp_out = (e >= 257 && e <= 639) ? onehot : 4'b0000;
            chk($sformatf("ch%0d_led_out_e%0d", ch, e),
                32'(bus.led_out), 32'(exp_out));
            chk($sformatf("ch%0d_pwm_wrap_e%0d", ch, e),
                32'(bus.pwm_wrap), 32'(e % 256 == 0));
            if (e == 255)
                chk($sformatf("ch%0d_load", ch), 32'(dut.bright[ch]), 255);
            if (e >= 256 && (e - 240) % 16 == 0) begin
                m = (e - 240) / 16;
                if (m <= 40)
                    chk($sformatf("ch%0d_decay_m%0d", ch, m),
                        32'(dut.bright[ch]), (m < 32) ? 255 - 8 * m : 0);
            end
            if (e >= 513 && e <= 768 && bus.led_out[ch]) hi++;
        end
        chk($sformatf("ch%0d_duty127_highs", ch), 32'(hi), 127);
    endtask

    function automatic int rot_exp(input int ch, input int k);
        if (k <= 4 * ch)     return 0;
        if (k <= 4 * ch + 4) return 256;
        if (k == 4 * ch + 5) return 135;
        if (k == 4 * ch + 6) return 7;
        return 0;
    endfunction

    initial begin
        int cnt [4];

        vecs[0] = '{pat: 4'b0000, exp_out: 4'b0000};
        vecs[1] = '{pat: 4'b0001, exp_out: 4'b0001};
        vecs[2] = '{pat: 4'b1000, exp_out: 4'b1000};
        vecs[3] = '{pat: 4'b1010, exp_out: 4'b1010};
        vecs[4] = '{pat: 4'b0110, exp_out: 4'b0110};
        vecs[5] = '{pat: 4'b1111, exp_out: 4'b1111};

        bus.led_in = '0;

        // Async reset mid-period must clear pins without a clock edge.
        do_reset();
        bus.led_in = 4'hF;
        repeat (512) step();
        chk("pre_rst_led_out", 32'(bus.led_out), 32'hF);
        chk("pre_rst_pwm_wrap", 32'(bus.pwm_wrap), 1);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_led_out", 32'(bus.led_out), 0);
        chk("async_rst_pwm_wrap", 32'(bus.pwm_wrap), 0);
        bus.led_in = '0;

        // Steady patterns: visible only after the first period boundary.
        for (int v = 0; v < 6; v++) begin
            do_reset();
            bus.led_in = vecs[v].pat;
            for (int e = 1; e <= 512; e++) begin
                step();
                if (e == 256) begin
                    chk($sformatf("vec%0d_out_e256", v),
                        32'(bus.led_out), 0);
                    chk($sformatf("vec%0d_wrap_e256", v),
                        32'(bus.pwm_wrap), 1);
                end
                if (e == 257 || e == 512)
                    chk($sformatf("vec%0d_out_e%0d", v, e),
                        32'(bus.led_out), 32'(vecs[v].exp_out));
            end
        end

        run_pulse(0);
        run_pulse(1);

        // Load on the same edge as a decay tick.
        do_reset();
        for (int e = 1; e <= 320; e++) begin
            bus.led_in = (e == 1)   ? 4'b1100 :
                         (e == 320) ? 4'b0100 : 4'b0000;
            step();
            if (e == 319)
                chk("ch2_pre_tick", 32'(dut.bright[2]), 103);
            if (e == 320) begin
                chk("ch2_load_beats_tick", 32'(dut.bright[2]), 255);
                chk("ch3_tick_only", 32'(dut.bright[3]), 95);
            end
        end
        bus.led_in = '0;

        // Rotating one-hot, 1024 clks per position: high count per period.
        do_reset();
        for (int ch = 0; ch < 4; ch++) cnt[ch] = 0;
        for (int e = 1; e <= 4096; e++) begin
            bus.led_in = 4'b0001 << ((e - 1) / 1024);
            step();
            for (int ch = 0; ch < 4; ch++)
                if (bus.led_out[ch]) cnt[ch]++;
            if (e % 256 == 0) begin
                for (int ch = 0; ch < 4; ch++) begin
                    chk($sformatf("rot_ch%0d_k%0d", ch, e / 256 - 1),
                        32'(cnt[ch]), 32'(rot_exp(ch, e / 256 - 1)));
                    cnt[ch] = 0;
                end
            end
        end
        bus.led_in = '0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
